// File: rtl/clkdiv_pkg.sv
// Shared constants and types for the multi-channel clock divider.
package clkdiv_pkg;

   localparam int CNT_W_DEFAULT = 26;
   localparam int MAX_CH        = 16;
   localparam int CH_IDX_W      = 4;

   localparam int DIV_MILI      = 5000;
   localparam int DIV_DEBOUNCE  = 5000;
   localparam int DIV_SECONDS   = 50000000;

   // What a channel does on the coming edge, in priority order.
   typedef enum logic [1:0] {
      CH_IDLE = 2'd0,
      CH_RUN  = 2'd1,
      CH_HALT = 2'd2,
      CH_CLR  = 2'd3
   } ch_mode_e;

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active/pending divisor pair and the
// registered clk_out / tick outputs.
module clkdiv_channel
   import clkdiv_pkg::*;
#(
   parameter int               CNT_W    = CNT_W_DEFAULT,
   parameter logic [CNT_W-1:0] DIV_INIT = '0
) (
   input  logic             clkin,
   input  logic             rst_n,
   input  logic             i_en,
   input  logic             i_sync_clr,
   input  logic             i_wr,
   input  logic [CNT_W-1:0] i_div,
   output logic             o_clk,
   output logic             o_tick
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_div_act;
   logic [CNT_W-1:0] r_div_pend;
   logic             r_clk;
   logic             r_tick;
   ch_mode_e         w_mode;
   logic             w_wrap;

   always_comb begin
      w_mode = CH_IDLE;
      if (i_sync_clr) begin
         w_mode = CH_CLR;
      end else if (r_div_act == '0) begin
         w_mode = CH_HALT;
      end else if (i_en) begin
         w_mode = CH_RUN;
      end
   end

   assign w_wrap = (w_mode == CH_RUN) && (r_cnt == r_div_act - CNT_W'(1));

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_div_act  <= DIV_INIT;
         r_div_pend <= DIV_INIT;
         r_clk      <= 1'b0;
         r_tick     <= 1'b0;
      end else begin
         r_tick <= w_wrap;
         if (i_wr) begin
            r_div_pend <= i_div;
         end
         case (w_mode)
            CH_CLR: begin
               r_cnt <= '0;
               r_clk <= 1'b0;
               if (i_wr) r_div_act <= i_div;
            end
            CH_HALT: begin
               r_cnt <= '0;
               if (i_wr) r_div_act <= i_div;
            end
            CH_RUN: begin
               if (w_wrap) begin
                  // A write landing on the wrap edge wins over the older pending value.
                  r_cnt     <= '0;
                  r_clk     <= ~r_clk;
                  r_div_act <= i_wr ? i_div : r_div_pend;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_clk  = r_clk;
   assign o_tick = r_tick;

endmodule

// File: rtl/multi_clock_divider.sv
// NUM_CH independent clock dividers sharing one divisor write port; the
// top decodes the write channel and flags out-of-range writes.
module multi_clock_divider
   import clkdiv_pkg::*;
#(
   parameter int                      NUM_CH  = 3,
   parameter int                      CNT_W   = CNT_W_DEFAULT,
   parameter logic [NUM_CH*CNT_W-1:0] DIV_RST = (NUM_CH*CNT_W)'({CNT_W'(DIV_MILI),
                                                                 CNT_W'(DIV_DEBOUNCE),
                                                                 CNT_W'(DIV_SECONDS)})
) (
   input  logic                clkin,
   input  logic                rst_n,
   input  logic [NUM_CH-1:0]   en,
   input  logic [NUM_CH-1:0]   sync_clr,
   input  logic                cfg_wr,
   input  logic [CH_IDX_W-1:0] cfg_ch,
   input  logic [CNT_W-1:0]    cfg_div,
   output logic                cfg_err,
   output logic [NUM_CH-1:0]   clk_out,
   output logic [NUM_CH-1:0]   tick
);

   localparam logic [CH_IDX_W:0] NUM_CH_L = (CH_IDX_W + 1)'(NUM_CH);

   // cfg_wr is a single-cycle strobe with no back-pressure: every cycle it is
   // high, cfg_ch/cfg_div are consumed on that same edge and never stalled.
   logic              w_ch_ok;
   logic [NUM_CH-1:0] w_wr;
   logic              r_cfg_err;

   assign w_ch_ok = {1'b0, cfg_ch} < NUM_CH_L;

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         r_cfg_err <= 1'b0;
      end else begin
         r_cfg_err <= cfg_wr && !w_ch_ok;
      end
   end

   assign cfg_err = r_cfg_err;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_wr[g] = cfg_wr && (cfg_ch == CH_IDX_W'(g));

      clkdiv_channel #(
         .CNT_W    (CNT_W),
         .DIV_INIT (DIV_RST[g*CNT_W +: CNT_W])
      ) u_ch (
         .clkin      (clkin),
         .rst_n      (rst_n),
         .i_en       (en[g]),
         .i_sync_clr (sync_clr[g]),
         .i_wr       (w_wr[g]),
         .i_div      (cfg_div),
         .o_clk      (clk_out[g]),
         .o_tick     (tick[g])
      );
   end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider: expected tick/cfg_err events go into
// a queue tagged with cycle, channel and clk_out level; a monitor pops them.
module tb_multi_clock_divider;

   localparam int NUM_CH = 3;
   localparam int CNT_W  = 8;
   localparam logic [NUM_CH*CNT_W-1:0] DIV_RST = {8'd4, 8'd3, 8'd2};
   localparam int ERR_CH = 15;

   logic              clkin = 1'b0;
   logic              rst_n;
   logic [NUM_CH-1:0] en;
   logic [NUM_CH-1:0] sync_clr;
   logic              cfg_wr;
   logic [3:0]        cfg_ch;
   logic [CNT_W-1:0]  cfg_div;
   logic              cfg_err;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] tick;

   multi_clock_divider #(
      .NUM_CH  (NUM_CH),
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_RST)
   ) dut (
      .clkin    (clkin),
      .rst_n    (rst_n),
      .en       (en),
      .sync_clr (sync_clr),
      .cfg_wr   (cfg_wr),
      .cfg_ch   (cfg_ch),
      .cfg_div  (cfg_div),
      .cfg_err  (cfg_err),
      .clk_out  (clk_out),
      .tick     (tick)
   );

   // ---------------- clock / cycle count ----------------
   always #5 clkin = ~clkin;

   int cyc = 0;
   always @(posedge clkin) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q[$];
   int n_cmp  = 0;
   int n_fail = 0;
   int e;

   function automatic logic [31:0] ev(input int c, input int ch, input logic lvl);
      logic [31:0] cv;
      logic [31:0] chv;
      cv  = 32'(c);
      chv = 32'(ch);
      return {cv[23:0], chv[3:0], 3'b000, lvl};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic observe(input logic [31:0] got);
      logic [31:0] x;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL unexpected_event: got %h expected none (cyc %0d)", got, cyc);
      end else begin
         x = exp_q.pop_front();
         check("event", got, x);
      end
   endtask

   always @(negedge clkin) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (tick[ch] === 1'b1) observe(ev(cyc, ch, clk_out[ch]));
      end
      if (cfg_err === 1'b1) observe(ev(cyc, ERR_CH, 1'b0));
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) @(negedge clkin);
   endtask

   task automatic push(input int c, input int ch, input logic lvl);
      exp_q.push_back(ev(c, ch, lvl));
   endtask

   // Reset divisors are ch0=2, ch1=3, ch2=4; all channels start from count 0
   // and clk_out 0 when enabled at cycle e0.
   task automatic expect_all(input int e0, input int n);
      int d;
      for (int t = 1; t <= n; t++) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            d = ch + 2;
            if (t % d == 0) push(e0 + t, ch, ((t / d) % 2) == 1);
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n    = 1'b1;
      en       = '0;
      sync_clr = '0;
      cfg_wr   = 1'b0;
      cfg_ch   = 4'd0;
      cfg_div  = '0;
      #1 rst_n = 1'b0;
      #2;
      check("rst_clk_out", 32'(clk_out), 32'd0);
      check("rst_tick",    32'(tick),    32'd0);
      check("rst_cfg_err", 32'(cfg_err), 32'd0);
      step(3);
      rst_n = 1'b1;
      step(2);

      // Reset divisors 2/3/4 running together.
      e  = cyc;
      en = 3'b111;
      expect_all(e, 12);
      step(12);
      en = 3'b000;
      step(2);

      // ch0 at D=5, write 2 at count 1: old period completes, then period 2.
      sync_clr = 3'b001; cfg_wr = 1'b1; cfg_ch = 4'd0; cfg_div = 8'd5;
      step(1);
      sync_clr = 3'b000; cfg_wr = 1'b0; en = 3'b001;
      e = cyc;
      push(e + 5, 0, 1'b1);
      push(e + 7, 0, 1'b0);
      push(e + 9, 0, 1'b1);
      push(e + 11, 0, 1'b0);
      step(1);
      cfg_wr = 1'b1; cfg_div = 8'd2;
      step(1);
      cfg_wr = 1'b0;
      step(9);
      en = 3'b000;
      step(2);

      // ch1 at D=5: write 3 on the wrap, then 0 (halt), then 4 (resume).
      sync_clr = 3'b010; cfg_wr = 1'b1; cfg_ch = 4'd1; cfg_div = 8'd5;
      step(1);
      sync_clr = 3'b000; cfg_wr = 1'b0; en = 3'b010;
      e = cyc;
      push(e + 5, 1, 1'b1);
      push(e + 8, 1, 1'b0);
      push(e + 11, 1, 1'b1);
      push(e + 21, 1, 1'b0);
      step(4);
      cfg_wr = 1'b1; cfg_div = 8'd3;
      step(1);
      cfg_wr = 1'b0;
      step(4);
      cfg_wr = 1'b1; cfg_div = 8'd0;
      step(1);
      cfg_wr = 1'b0;
      step(6);
      check("halt_clk_out1", 32'(clk_out[1]), 32'd1);
      check("halt_tick1",    32'(tick[1]),    32'd0);
      cfg_wr = 1'b1; cfg_div = 8'd4;
      step(1);
      cfg_wr = 1'b0;
      step(4);
      en = 3'b000;
      step(2);

      // ch2 at D=4: pause 10 cycles at count 1, then sync_clr with clk_out high.
      sync_clr = 3'b100;
      step(1);
      sync_clr = 3'b000; en = 3'b100;
      e = cyc;
      push(e + 4, 2, 1'b1);
      push(e + 18, 2, 1'b0);
      push(e + 22, 2, 1'b1);
      push(e + 28, 2, 1'b1);
      step(5);
      en = 3'b000;
      step(5);
      check("frozen_clk_out2", 32'(clk_out[2]), 32'd1);
      step(5);
      en = 3'b100;
      step(8);
      sync_clr = 3'b100;
      step(1);
      check("clr_clk_out2", 32'(clk_out[2]), 32'd0);
      sync_clr = 3'b000;
      step(4);
      en = 3'b000;
      step(2);

      // Out-of-range write: one cfg_err pulse, divisors unchanged.
      cfg_wr = 1'b1; cfg_ch = 4'd7; cfg_div = 8'd9;
      push(cyc + 1, ERR_CH, 1'b0);
      step(1);
      cfg_wr = 1'b0; sync_clr = 3'b111;
      step(1);
      sync_clr = 3'b000; en = 3'b111;
      e = cyc;
      push(e + 2, 0, 1'b1);
      push(e + 4, 0, 1'b0);
      push(e + 4, 1, 1'b1);
      push(e + 4, 2, 1'b1);
      push(e + 6, 0, 1'b1);
      step(6);

      // Reset in the middle of a period, with ch0 tick and clk_out high.
      #2 rst_n = 1'b0;
      #1;
      check("midrst_clk_out", 32'(clk_out), 32'd0);
      check("midrst_tick",    32'(tick),    32'd0);
      check("midrst_cfg_err", 32'(cfg_err), 32'd0);
      step(3);
      rst_n = 1'b1;
      e = cyc;
      expect_all(e, 12);
      step(12);
      en = 3'b000;
      step(4);

      while (exp_q.size() > 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL missing_event: got none expected %h", exp_q.pop_front());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_clock_divider.md
MULTI_CLOCK_DIVIDER -- requirements
Module: multi_clock_divider

Interface
REQ-001 Parameter NUM_CH, default 3: number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 26: width of each divisor and counter.
REQ-003 Parameter DIV_RST, default {5000, 5000, 50000000} (channel 0 in LSBs), NUM_CH*CNT_W bits: per-channel divisor loaded at reset.
REQ-004 clkin  input  1  sole system clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 en  input  NUM_CH  per-channel run enable.
REQ-007 sync_clr  input  NUM_CH  per-channel synchronous counter/phase clear.
REQ-008 cfg_wr  input  1  single-cycle divisor write strobe.
REQ-009 cfg_ch  input  4  target channel of the write.
REQ-010 cfg_div  input  CNT_W  divisor value to write.
REQ-011 cfg_err  output  1  one-cycle pulse flagging a rejected write.
REQ-012 clk_out  output  NUM_CH  per-channel toggled divided clock, registered.
REQ-013 tick  output  NUM_CH  per-channel one-cycle enable pulse at each wrap, registered.

Function
REQ-014 Each channel SHALL hold a CNT_W counter, an active divisor and a pending divisor.
REQ-015 With en[i]=1 and active divisor D>=1, the counter SHALL count 0..D-1, then wrap to 0.
REQ-016 On the cycle after the counter equals D-1, tick[i] SHALL be 1 for exactly one cycle and clk_out[i] SHALL toggle.
REQ-017 Resulting periods: tick every D cycles; clk_out period 2*D cycles, 50% duty.
REQ-018 D=1: tick stays high continuously; clk_out toggles every cycle.
REQ-019 D=0: channel halted; counter held at 0, tick 0, clk_out holds its value.
REQ-020 en[i]=0: counter and clk_out hold; tick[i]=0; counting resumes from the held value when en[i] returns to 1.
REQ-021 sync_clr[i]=1: counter and clk_out[i] SHALL be 0 and tick[i] 0 on the next cycle; sync_clr overrides en and any wrap.
REQ-022 Writes: cfg_wr with cfg_ch<NUM_CH loads cfg_div into that channel's pending divisor.
REQ-023 The active divisor SHALL take the pending value at the channel's next wrap; the current period always completes with the old divisor.
REQ-024 A write coinciding with a wrap of the target channel SHALL load cfg_div directly into the active divisor at that wrap.
REQ-025 A write to a channel whose active divisor is 0, or which is in sync_clr, SHALL update the active divisor immediately.
REQ-026 cfg_wr with cfg_ch>=NUM_CH SHALL be ignored, with cfg_err=1 on the next cycle; otherwise cfg_err=0.
REQ-027 Channels SHALL be fully independent; a write affects only the addressed channel.

Reset
REQ-028 rst_n=0 SHALL immediately set all counters to 0, clk_out to 0, tick to 0 and cfg_err to 0.
REQ-029 rst_n=0 SHALL load the active and pending divisors from DIV_RST.
REQ-030 Reset deasserting mid-period SHALL restart counting from 0; no partial tick.

Structure
REQ-031 Package clkdiv_pkg SHALL hold CNT_W default, MAX_CH=16, and named reset divisors DIV_MILI=5000, DIV_DEBOUNCE=5000, DIV_SECONDS=50000000.
REQ-032 One sub-module clkdiv_channel (counter, divisor shadow, clk_out/tick registers) SHALL be instantiated NUM_CH times via generate.
REQ-033 Write decode and cfg_err SHALL live in the top level.

Verification
REQ-034 Reset, en=3'b111, defaults overridden to DIV_RST={4,3,2} -> tick[0] every 2 cycles, tick[1] every 3, tick[2] every 4; clk_out periods 4/6/8.
REQ-035 Ch0 D=5, write cfg_div=2 at count 1 -> current period ends after 5 cycles, then ticks every 2.
REQ-036 Write cfg_div=3 to ch1 on its wrap cycle -> next period 3 cycles; write cfg_div=0 -> ch1 halts; write 4 -> ticks resume within 4 cycles.
REQ-037 en[2] low for 10 cycles at count 1 of D=4 -> no tick and clk_out frozen; tick 3 cycles after re-enable; sync_clr[2] pulse -> clk_out[2]=0, count restarts.
REQ-038 cfg_wr with cfg_ch=7, NUM_CH=3 -> cfg_err pulses 1 cycle, no divisor change; rst_n low mid-period -> all outputs 0 immediately, DIV_RST restored.
